// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller driven by a qualified tick, with a latched
// side-road request, bounded side-green extension and a flashing night mode.
module traffic_light_ctrl #(
    parameter int T_MAIN_G     = 5,
    parameter int T_SIDE_G     = 5,
    parameter int T_Y          = 3,
    parameter int T_AR         = 1,
    parameter int SIDE_EXT_MAX = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       en,
    input  logic       car,
    input  logic       flash,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [7:0] main_bcd,
    output logic [7:0] side_bcd,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAIN_G = 3'd1,
        MAIN_Y = 3'd2,
        AR_MS  = 3'd3,
        SIDE_G = 3'd4,
        SIDE_Y = 3'd5,
        AR_SM  = 3'd6,
        FLASH  = 3'd7
    } state_t;

    localparam logic [3:0] EXT_MAX = 4'(SIDE_EXT_MAX);

    state_t     r_state, w_state_nxt;
    logic [6:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_ext_cnt, w_ext_nxt;
    logic       r_car_req, w_car_req_nxt;
    logic       r_flash_ph, w_flash_ph_nxt;
    logic       w_qtick;
    logic       w_req;

    function automatic logic [6:0] phase_len(input state_t s);
        case (s)
            MAIN_G:         return 7'(T_MAIN_G);
            MAIN_Y, SIDE_Y: return 7'(T_Y);
            AR_MS, AR_SM:   return 7'(T_AR);
            SIDE_G:         return 7'(T_SIDE_G);
            default:        return 7'd0;
        endcase
    endfunction

    function automatic logic [2:0] main_lamp(input state_t s, input logic ph);
        case (s)
            IDLE, MAIN_G: return 3'b001;
            MAIN_Y:       return 3'b010;
            FLASH:        return ph ? 3'b010 : 3'b000;
            default:      return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(input state_t s, input logic ph);
        case (s)
            SIDE_G:  return 3'b001;
            SIDE_Y:  return 3'b010;
            FLASH:   return ph ? 3'b010 : 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [7:0] countdown(input state_t s, input logic [6:0] c);
        case (s)
            IDLE:    return 8'h99;
            FLASH:   return 8'hFF;
            default: return {4'(c / 7'd10), 4'(c % 7'd10)};
        endcase
    endfunction

    assign w_qtick = tick & en;
    // A car seen on this very edge already counts as a pending request.
    assign w_req   = r_car_req | car;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ext_nxt      = r_ext_cnt;
        w_flash_ph_nxt = r_flash_ph;
        if (w_qtick) begin
            if (r_state != FLASH && flash) begin
                w_state_nxt    = FLASH;
                w_flash_ph_nxt = 1'b0;
                w_cnt_nxt      = 7'd0;
            end else if (r_state == FLASH) begin
                if (!flash) begin
                    w_state_nxt = AR_SM;
                    w_cnt_nxt   = phase_len(AR_SM);
                end else begin
                    w_flash_ph_nxt = ~r_flash_ph;
                end
            end else if (r_state == IDLE) begin
                if (w_req) begin
                    w_state_nxt = MAIN_G;
                    w_cnt_nxt   = phase_len(MAIN_G);
                end
            end else if (r_cnt > 7'd1) begin
                w_cnt_nxt = r_cnt - 7'd1;
            end else begin
                case (r_state)
                    MAIN_G: w_state_nxt = MAIN_Y;
                    MAIN_Y: w_state_nxt = AR_MS;
                    AR_MS: begin
                        w_state_nxt = SIDE_G;
                        w_ext_nxt   = 4'd0;
                    end
                    SIDE_G: w_state_nxt = SIDE_Y;
                    SIDE_Y: begin
                        if (w_req && r_ext_cnt < EXT_MAX) begin
                            w_state_nxt = SIDE_G;
                            w_ext_nxt   = r_ext_cnt + 4'd1;
                        end else begin
                            w_state_nxt = AR_SM;
                        end
                    end
                    AR_SM:   w_state_nxt = IDLE;
                    default: w_state_nxt = r_state;
                endcase
                w_cnt_nxt = phase_len(w_state_nxt);
            end
        end
        w_car_req_nxt = car | (r_car_req & ~(w_state_nxt == SIDE_G && r_state != SIDE_G));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 7'd0;
            r_ext_cnt  <= 4'd0;
            r_car_req  <= 1'b0;
            r_flash_ph <= 1'b0;
            main_light <= 3'b001;
            side_light <= 3'b100;
            main_bcd   <= 8'h99;
            side_bcd   <= 8'h99;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ext_cnt  <= w_ext_nxt;
            r_car_req  <= w_car_req_nxt;
            r_flash_ph <= w_flash_ph_nxt;
            main_light <= main_lamp(w_state_nxt, w_flash_ph_nxt);
            side_light <= side_lamp(w_state_nxt, w_flash_ph_nxt);
            main_bcd   <= countdown(w_state_nxt, w_cnt_nxt);
            side_bcd   <= countdown(w_state_nxt, w_cnt_nxt);
        end
    end

    assign state_out = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a table-driven service cycle, directed corner
// sequences and random stimulus scored against a phase-table model.
module tb_traffic_light_ctrl;

    localparam int T_MAIN_G     = 5;
    localparam int T_SIDE_G     = 5;
    localparam int T_Y          = 3;
    localparam int T_AR         = 1;
    localparam int SIDE_EXT_MAX = 2;

    logic       clk = 1'b0;
    logic       clk_run = 1'b1;
    logic       rst = 1'b1;
    logic       tick = 1'b0, en = 1'b1, car = 1'b0, flash = 1'b0;
    logic [2:0] main_light, side_light, state_out;
    logic [7:0] main_bcd, side_bcd;

    int n_chk = 0;
    int n_pass = 0;

    traffic_light_ctrl #(
        .T_MAIN_G(T_MAIN_G), .T_SIDE_G(T_SIDE_G), .T_Y(T_Y),
        .T_AR(T_AR), .SIDE_EXT_MAX(SIDE_EXT_MAX)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .en(en), .car(car), .flash(flash),
        .main_light(main_light), .side_light(side_light),
        .main_bcd(main_bcd), .side_bcd(side_bcd), .state_out(state_out)
    );

    always #5 if (clk_run) clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: phase tables indexed by state number
    int m_st, m_cnt, m_ext;
    bit m_req, m_ph;
    int dur[8]   = '{0, T_MAIN_G, T_Y, T_AR, T_SIDE_G, T_Y, T_AR, 0};
    int after[8] = '{1, 2, 3, 4, 5, 6, 0, 6};
    logic [2:0] mlamp[8] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
    logic [2:0] slamp[8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_ext = 0; m_req = 0; m_ph = 0;
    endtask

    task automatic model_step(input bit t, input bit e, input bit c, input bit f);
        bit eff;
        int prev;
        bit nreq;
        eff  = m_req | c;
        prev = m_st;
        nreq = m_req | c;
        if (t && e) begin
            if (m_st != 7 && f) begin
                m_st = 7; m_ph = 0;
            end else if (m_st == 7) begin
                if (!f) begin m_st = 6; m_cnt = T_AR; end
                else m_ph = !m_ph;
            end else if (m_st == 0) begin
                if (eff) begin m_st = 1; m_cnt = T_MAIN_G; end
            end else if (m_cnt > 1) begin
                m_cnt--;
            end else begin
                if (m_st == 5 && eff && m_ext < SIDE_EXT_MAX) begin
                    m_st = 4; m_ext++;
                end else begin
                    if (m_st == 3) m_ext = 0;
                    m_st = after[m_st];
                end
                m_cnt = dur[m_st];
            end
        end
        if (m_st == 4 && prev != 4) nreq = c;
        m_req = nreq;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_model(input string tag);
        logic [7:0] eb;
        logic [2:0] eml, esl;
        if (m_st == 7) begin
            eb = 8'hFF; eml = m_ph ? 3'b010 : 3'b000; esl = eml;
        end else begin
            eb = (m_st == 0) ? 8'h99 : {4'(m_cnt / 10), 4'(m_cnt % 10)};
            eml = mlamp[m_st]; esl = slamp[m_st];
        end
        chk({tag, "_state"}, {5'd0, state_out}, 8'(m_st));
        chk({tag, "_main_light"}, {5'd0, main_light}, {5'd0, eml});
        chk({tag, "_side_light"}, {5'd0, side_light}, {5'd0, esl});
        chk({tag, "_main_bcd"}, main_bcd, eb);
        chk({tag, "_side_bcd"}, side_bcd, eb);
    endtask

    task automatic chk_out(input string tag, input logic [2:0] st, input logic [2:0] ml,
                           input logic [2:0] sl, input logic [7:0] bcd);
        chk({tag, "_state"}, {5'd0, state_out}, {5'd0, st});
        chk({tag, "_main_light"}, {5'd0, main_light}, {5'd0, ml});
        chk({tag, "_side_light"}, {5'd0, side_light}, {5'd0, sl});
        chk({tag, "_main_bcd"}, main_bcd, bcd);
        chk({tag, "_side_bcd"}, side_bcd, bcd);
    endtask

    task automatic step(input bit t, input bit e, input bit c, input bit f);
        @(negedge clk);
        tick = t; en = e; car = c; flash = f;
        @(posedge clk);
        model_step(t, e, c, f);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        tick = 0; en = 1; car = 0; flash = 0;
        rst = 0;
        model_reset();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic tick_until(input int target, input bit c, input int maxn);
        int n;
        n = 0;
        while (state_out != 3'(target) && n < maxn) begin
            step(1, 1, c, 0);
            n++;
        end
        chk("reach_state", {5'd0, state_out}, 8'(target));
    endtask

    typedef struct {
        bit t, e, c, f;
        logic [2:0] st, ml, sl;
        logic [7:0] bcd;
    } vec_t;

    function automatic vec_t mk(bit t, bit c, logic [2:0] st, logic [2:0] ml,
                                logic [2:0] sl, logic [7:0] bcd);
        vec_t v;
        v.t = t; v.e = 1; v.c = c; v.f = 0;
        v.st = st; v.ml = ml; v.sl = sl; v.bcd = bcd;
        return v;
    endfunction

    initial begin
        vec_t vt[21];
        int grants, nloop;
        bit saw_ar;
        logic [2:0] prev;

        vt[0]  = mk(0, 1, 3'd0, 3'b001, 3'b100, 8'h99);
        vt[1]  = mk(1, 0, 3'd1, 3'b001, 3'b100, 8'h05);
        vt[2]  = mk(1, 0, 3'd1, 3'b001, 3'b100, 8'h04);
        vt[3]  = mk(1, 0, 3'd1, 3'b001, 3'b100, 8'h03);
        vt[4]  = mk(1, 0, 3'd1, 3'b001, 3'b100, 8'h02);
        vt[5]  = mk(1, 0, 3'd1, 3'b001, 3'b100, 8'h01);
        vt[6]  = mk(1, 0, 3'd2, 3'b010, 3'b100, 8'h03);
        vt[7]  = mk(1, 0, 3'd2, 3'b010, 3'b100, 8'h02);
        vt[8]  = mk(1, 0, 3'd2, 3'b010, 3'b100, 8'h01);
        vt[9]  = mk(1, 0, 3'd3, 3'b100, 3'b100, 8'h01);
        vt[10] = mk(1, 0, 3'd4, 3'b100, 3'b001, 8'h05);
        vt[11] = mk(1, 0, 3'd4, 3'b100, 3'b001, 8'h04);
        vt[12] = mk(1, 0, 3'd4, 3'b100, 3'b001, 8'h03);
        vt[13] = mk(1, 0, 3'd4, 3'b100, 3'b001, 8'h02);
        vt[14] = mk(1, 0, 3'd4, 3'b100, 3'b001, 8'h01);
        vt[15] = mk(1, 0, 3'd5, 3'b100, 3'b010, 8'h03);
        vt[16] = mk(1, 0, 3'd5, 3'b100, 3'b010, 8'h02);
        vt[17] = mk(1, 0, 3'd5, 3'b100, 3'b010, 8'h01);
        vt[18] = mk(1, 0, 3'd6, 3'b100, 3'b100, 8'h01);
        vt[19] = mk(1, 0, 3'd0, 3'b001, 3'b100, 8'h99);
        vt[20] = mk(1, 0, 3'd0, 3'b001, 3'b100, 8'h99);

        // Reset values without any clock edge
        #2 rst = 0;
        model_reset();
        #2;
        chk_out("reset", 3'd0, 3'b001, 3'b100, 8'h99);
        @(negedge clk);
        rst = 1;

        // Idle hold
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0);
            chk_out("idle_hold", 3'd0, 3'b001, 3'b100, 8'h99);
        end

        // Full service cycle from the vector table
        do_reset();
        for (int i = 0; i < 21; i++) begin
            step(vt[i].t, vt[i].e, vt[i].c, vt[i].f);
            chk_out($sformatf("vec%0d", i), vt[i].st, vt[i].ml, vt[i].sl, vt[i].bcd);
        end

        // Extension cap with car held high
        do_reset();
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        chk("ext_enter_main", {5'd0, state_out}, 8'd1);
        grants = 0; saw_ar = 0; nloop = 0;
        while (state_out != 3'd0 && nloop < 200) begin
            prev = state_out;
            step(1, 1, 1, 0);
            if (state_out == 3'd4 && prev != 3'd4) grants++;
            if (state_out == 3'd6) saw_ar = 1;
            nloop++;
        end
        chk("ext_grants", 8'(grants), 8'd3);
        chk("ext_saw_ar_sm", {7'd0, saw_ar}, 8'd1);
        chk("ext_back_idle", {5'd0, state_out}, 8'd0);
        step(1, 1, 1, 0);
        chk("ext_main_again", {5'd0, state_out}, 8'd1);

        // Night mode entered from SIDE_G
        do_reset();
        step(0, 1, 1, 0);
        tick_until(4, 0, 100);
        step(1, 1, 0, 1);
        chk_out("flash_a", 3'd7, 3'b000, 3'b000, 8'hFF);
        step(1, 1, 0, 1);
        chk_out("flash_b", 3'd7, 3'b010, 3'b010, 8'hFF);
        step(1, 1, 0, 1);
        chk_out("flash_c", 3'd7, 3'b000, 3'b000, 8'hFF);
        step(1, 1, 0, 0);
        chk_out("flash_exit", 3'd6, 3'b100, 3'b100, 8'h01);
        step(1, 1, 0, 0);
        chk_out("flash_idle", 3'd0, 3'b001, 3'b100, 8'h99);

        // Freeze in MAIN_Y at count 2
        do_reset();
        step(0, 1, 1, 0);
        tick_until(2, 0, 100);
        step(1, 1, 0, 0);
        chk_out("freeze_pre", 3'd2, 3'b010, 3'b100, 8'h02);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0);
            chk_out("freeze_hold", 3'd2, 3'b010, 3'b100, 8'h02);
        end
        step(1, 1, 0, 0);
        chk_out("freeze_run", 3'd2, 3'b010, 3'b100, 8'h01);
        step(1, 1, 0, 0);
        chk_out("freeze_ar", 3'd3, 3'b100, 3'b100, 8'h01);

        // Asynchronous reset mid SIDE_Y with the clock stopped
        do_reset();
        step(0, 1, 1, 0);
        tick_until(5, 0, 100);
        @(negedge clk);
        tick = 0;
        clk_run = 0;
        #3 rst = 0;
        model_reset();
        #1;
        chk_out("async_rst", 3'd0, 3'b001, 3'b100, 8'h99);
        #10 rst = 1;
        #2 clk_run = 1;
        step(0, 1, 0, 0);
        chk_out("after_rst", 3'd0, 3'b001, 3'b100, 8'h99);

        // Random stimulus against the model
        do_reset();
        begin
            bit rf;
            rf = 0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 39) == 0) rf = !rf;
                step($urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0,
                     $urandom_range(0, 9) == 0, rf);
                chk_model("rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
